// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART bus responder.
// UART_RESP_PARITY_EN selects 8E1 framing (adds the PARITY states).
package uart_pkg;

  localparam int FRAME_DATA_BITS = 8;

`ifdef UART_RESP_PARITY_EN
  localparam int FRAME_BITS = 11;
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;
`else
  localparam int FRAME_BITS = 10;
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
  } rx_state_t;
`endif

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int calc_half(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..DIV-1 while enabled and flags the last cycle.
// half_load preloads so the first tick lands HALF cycles later (mid-bit sampling).
module uart_bit_timer #(
  parameter int DIV  = 10,
  parameter int HALF = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic half_load,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST       = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_START = CW'(DIV - HALF);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      count <= '0;
    end else if (half_load) begin
      count <= HALF_START;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/uart_bus_responder.sv
// Device side of the parallel UART strobe bus: THR/RX holding registers plus 8N1 serializer/deserializer.
// Define UART_RESP_PARITY_EN for 8E1 frames (even parity after D7, checked on receive).
module uart_bus_responder
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  input  logic [7:0] bus_data_i,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  output logic       txd,
  input  logic       rxd
);

  localparam int DIV  = calc_div(CLK_HZ, BAUD);
  localparam int HALF = calc_half(DIV);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  // Strobe handshake: a bus cycle is the low phase of uart_wrn/uart_rdn; it completes
  // on the synced rising edge, where a write commits to THR and a read clears dataready.
  logic [SYNC_STAGES-1:0] rdn_sync, wrn_sync, rxd_sync;
  logic rdn_prev, wrn_prev, rxd_prev;
  logic rdn_s, wrn_s, rxd_s;
  logic rd_done, wr_commit, rxd_fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdn_sync <= '1;
      wrn_sync <= '1;
      rxd_sync <= '1;
      rdn_prev <= 1'b1;
      wrn_prev <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rdn_sync <= {rdn_sync[SYNC_STAGES-2:0], uart_rdn};
      wrn_sync <= {wrn_sync[SYNC_STAGES-2:0], uart_wrn};
      rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], rxd};
      rdn_prev <= rdn_s;
      wrn_prev <= wrn_s;
      rxd_prev <= rxd_s;
    end
  end

  assign rdn_s     = rdn_sync[SYNC_STAGES-1];
  assign wrn_s     = wrn_sync[SYNC_STAGES-1];
  assign rxd_s     = rxd_sync[SYNC_STAGES-1];
  assign rd_done   = rdn_s & ~rdn_prev;
  assign wr_commit = wrn_s & ~wrn_prev;
  assign rxd_fall  = ~rxd_s & rxd_prev;

  logic [7:0] rx_hold;
  assign bus_data_oe = ~uart_rdn;
  assign bus_data_o  = rx_hold;

  // ---------------- transmitter ----------------
  tx_state_t  tx_state;
  logic [7:0] wr_sample, thr, tsr;
  logic [2:0] tx_bit;
  logic       tx_load, tx_tick;
`ifdef UART_RESP_PARITY_EN
  logic       tx_par;
`endif

  assign tx_load = (tx_state == TX_IDLE) && !uart_tbre;

  uart_bit_timer #(.DIV(DIV), .HALF(HALF)) u_tx_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .half_load (1'b0),
    .en        (tx_state != TX_IDLE),
    .tick      (tx_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      wr_sample <= '0;
      thr       <= '0;
      tsr       <= '0;
      tx_bit    <= '0;
      txd       <= 1'b1;
      uart_tbre <= 1'b1;
      uart_tsre <= 1'b1;
`ifdef UART_RESP_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      if (!wrn_s) wr_sample <= bus_data_i;
      case (tx_state)
        TX_IDLE: begin
          if (!uart_tbre) begin
            tsr       <= thr;
`ifdef UART_RESP_PARITY_EN
            tx_par    <= ^thr;
`endif
            uart_tbre <= 1'b1;
            uart_tsre <= 1'b0;
            txd       <= 1'b0;
            tx_state  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            txd      <= tsr[0];
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_bit == LAST_BIT) begin
              tx_bit   <= '0;
`ifdef UART_RESP_PARITY_EN
              txd      <= tx_par;
              tx_state <= TX_PARITY;
`else
              txd      <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_bit <= tx_bit + 3'd1;
              txd    <= tsr[tx_bit + 3'd1];
            end
          end
        end
`ifdef UART_RESP_PARITY_EN
        TX_PARITY: begin
          if (tx_tick) begin
            txd      <= 1'b1;
            tx_state <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (tx_tick) begin
            // A pending THR chains straight into the next start bit.
            if (!uart_tbre) begin
              tsr       <= thr;
`ifdef UART_RESP_PARITY_EN
              tx_par    <= ^thr;
`endif
              uart_tbre <= 1'b1;
              txd       <= 1'b0;
              tx_state  <= TX_START;
            end else begin
              uart_tsre <= 1'b1;
              tx_state  <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
      // Placed last so a commit colliding with a THR->TSR transfer leaves tbre low.
      if (wr_commit) begin
        thr       <= wr_sample;
        uart_tbre <= 1'b0;
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t  rx_state;
  logic [7:0] rx_sr;
  logic [2:0] rx_bit;
  logic       rx_tick, rx_start;
`ifdef UART_RESP_PARITY_EN
  logic       rx_par_ok;
`endif

  assign rx_start = (rx_state == RX_IDLE) && rxd_fall;

  uart_bit_timer #(.DIV(DIV), .HALF(HALF)) u_rx_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .half_load (rx_start),
    .en        ((rx_state != RX_IDLE) && (rx_state != RX_BREAK)),
    .tick      (rx_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state       <= RX_IDLE;
      rx_sr          <= '0;
      rx_hold        <= '0;
      rx_bit         <= '0;
      uart_dataready <= 1'b0;
`ifdef UART_RESP_PARITY_EN
      rx_par_ok      <= 1'b1;
`endif
    end else begin
      if (rd_done) uart_dataready <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_fall) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_tick) begin
            if (rxd_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_sr[rx_bit] <= rxd_s;
            if (rx_bit == LAST_BIT) begin
              rx_bit   <= '0;
`ifdef UART_RESP_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end
        end
`ifdef UART_RESP_PARITY_EN
        RX_PARITY: begin
          if (rx_tick) begin
            rx_par_ok <= ((^rx_sr) == rxd_s);
            rx_state  <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (rx_tick) begin
`ifdef UART_RESP_PARITY_EN
            if (rxd_s && rx_par_ok) begin
`else
            if (rxd_s) begin
`endif
              rx_hold        <= rx_sr;
              uart_dataready <= 1'b1;
              rx_state       <= RX_IDLE;
            end else begin
              rx_state <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          if (rxd_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed + randomized bench for uart_bus_responder at DIV=10 (1 MHz / 100 kBd).
// Build with UART_RESP_PARITY_EN defined to exercise the 8E1 frame variant.
module tb_uart_bus_responder;
  import uart_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;
`ifdef UART_RESP_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FL     = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FL     = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rdn = 1'b1;
  logic       uart_wrn = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] bus_data_i = 8'h00;
  logic [7:0] bus_data_o;
  logic       bus_data_oe, uart_dataready, uart_tbre, uart_tsre, txd;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_hold;
  logic       m_ready;

  uart_bus_responder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_rdn       (uart_rdn),
    .uart_wrn       (uart_wrn),
    .bus_data_i     (bus_data_i),
    .bus_data_o     (bus_data_o),
    .bus_data_oe    (bus_data_oe),
    .uart_dataready (uart_dataready),
    .uart_tbre      (uart_tbre),
    .uart_tsre      (uart_tsre),
    .txd            (txd),
    .rxd            (rxd)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line image of one frame, bit 0 first on the wire.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic par_flip,
                                              input logic stop);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
    if (PAR_EN) begin
      f[9]  = (^b) ^ par_flip;
      f[10] = stop;
    end else begin
      f[9] = stop;
    end
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [7:0] b);
    bus_data_i = b;
    uart_wrn = 1'b0;
    cyc(3);
    uart_wrn = 1'b1;
    cyc(4);
  endtask

  task automatic bus_read(output logic [7:0] d, output logic oe);
    uart_rdn = 1'b0;
    #1;
    oe = bus_data_oe;
    d  = bus_data_o;
    cyc(3);
    uart_rdn = 1'b1;
    cyc(4);
    m_ready = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input logic par_flip);
    logic [10:0] fb;
    fb = frame_bits(b, par_flip, stop);
    for (int k = 0; k < FL; k++) begin
      rxd = fb[k];
      cyc(DIV);
    end
    rxd = 1'b1;
    if (stop && !par_flip) begin
      m_hold  = b;
      m_ready = 1'b1;
    end
  endtask

  // ---------------- TX scoreboard ----------------
  // Waits for a start bit, then checks nframes contiguous frames against exp_q.
  task automatic tx_check_stream(input int nframes);
    int   waited, last_low;
    bit   found, tsre_busy;
    logic [10:0] fb;
    logic [7:0]  b;
    logic [DIV-1:0] samp;
    found = 0;
    waited = 0;
    last_low = -100;
    tsre_busy = 1;
    for (int i = 0; i < 60 && !found; i++) begin
      if (uart_tbre === 1'b0) last_low = i;
      if (txd === 1'b0) begin
        found = 1;
        waited = i;
      end else begin
        cyc(1);
      end
    end
    check("tx_start_seen", 32'(found), 1);
    if (!found) return;
    check("tbre_after_transfer", 32'(uart_tbre), 1);
    check("tbre_low_within_2", 32'((waited - last_low) >= 1 && (waited - last_low) <= 2), 1);
    for (int f = 0; f < nframes; f++) begin
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      fb = frame_bits(b, 1'b0, 1'b1);
      for (int k = 0; k < FL; k++) begin
        for (int c = 0; c < DIV; c++) begin
          if (f + k + c > 0) cyc(1);
          samp[c] = txd;
          if (uart_tsre !== 1'b0) tsre_busy = 0;
        end
        check($sformatf("tx_f%0d_b%0d_byte%02h_bit%0d", f, k, b, k), 32'(samp), 32'({DIV{fb[k]}}));
      end
    end
    check("tsre_low_during_frames", 32'(tsre_busy), 1);
    cyc(1);
    check("tsre_after_last_stop", 32'(uart_tsre), 1);
    check("txd_idle_after_stop", 32'(txd), 1);
  endtask

  task automatic tx_run(input logic [7:0] b0, input logic [7:0] b1, input int n);
    exp_q.push_back(b0);
    if (n > 1) exp_q.push_back(b1);
    fork
      tx_check_stream(n);
      begin
        bus_write(b0);
        if (n > 1) bus_write(b1);
      end
    join
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] rd_data, rb;
  logic       rd_oe;

  initial begin
    m_hold  = 8'h00;
    m_ready = 1'b0;
    cyc(3);
    check("rst_txd", 32'(txd), 1);
    check("rst_tbre", 32'(uart_tbre), 1);
    check("rst_tsre", 32'(uart_tsre), 1);
    check("rst_dataready", 32'(uart_dataready), 0);
    check("rst_bus_data_o", 32'(bus_data_o), 0);
    check("rst_oe", 32'(bus_data_oe), 0);
    rst_n = 1'b1;
    cyc(2);

    // Single frame, then two contiguous frames.
    tx_run(8'hA5, 8'h00, 1);
    cyc(5);
    tx_run(8'h11, 8'h22, 2);
    cyc(5);

    // Receive 0x3C and read it back over the strobe bus.
    rx_send(8'h3C, 1'b1, 1'b0);
    cyc(2);
    check("rx_3c_ready", 32'(uart_dataready), 32'(m_ready));
    check("rx_3c_hold", 32'(bus_data_o), 32'(m_hold));
    bus_read(rd_data, rd_oe);
    check("rd_oe_during_strobe", 32'(rd_oe), 1);
    check("rd_data_3c", 32'(rd_data), 32'h3C);
    check("rd_oe_released", 32'(bus_data_oe), 0);
    check("rd_clears_ready", 32'(uart_dataready), 32'(m_ready));

    // Start-bit glitch is rejected.
    rxd = 1'b0;
    cyc(5);
    rxd = 1'b1;
    cyc(20);
    check("glitch_no_ready", 32'(uart_dataready), 0);
    check("glitch_rx_idle", 32'(dut.rx_state), 32'(RX_IDLE));

    // Framing error discards the byte.
    rx_send(8'h81, 1'b0, 1'b0);
    cyc(20);
    check("frame_err_no_ready", 32'(uart_dataready), 32'(m_ready));
    check("frame_err_hold_kept", 32'(bus_data_o), 32'(m_hold));

    // Randomized receive, including an unread overrun.
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      rx_send(rb, 1'b1, 1'b0);
      cyc(2);
      check($sformatf("rx_rand%0d_ready", i), 32'(uart_dataready), 32'(m_ready));
      check($sformatf("rx_rand%0d_hold", i), 32'(bus_data_o), 32'(m_hold));
    end
    bus_read(rd_data, rd_oe);
    check("rd_after_overrun", 32'(rd_data), 32'(m_hold));
    check("ready_after_overrun_read", 32'(uart_dataready), 32'(m_ready));

    // Randomized transmit.
    for (int i = 0; i < 2; i++) begin
      tx_run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1 + (i % 2));
      cyc(3);
    end

    // Reset in the middle of a frame aborts it.
    bus_write(8'hA5);
    cyc(30);
    rst_n = 1'b0;
    cyc(1);
    m_hold  = 8'h00;
    m_ready = 1'b0;
    check("midrst_txd", 32'(txd), 1);
    check("midrst_tbre", 32'(uart_tbre), 1);
    check("midrst_tsre", 32'(uart_tsre), 1);
    check("midrst_hold", 32'(bus_data_o), 32'(m_hold));
    rst_n = 1'b1;
    cyc(3);
    exp_q.delete();
    tx_run(8'($urandom_range(0, 255)), 8'h00, 1);
    cyc(5);

`ifdef UART_RESP_PARITY_EN
    tx_run(8'h07, 8'h00, 1);
    cyc(5);
    rx_send(8'h07, 1'b1, 1'b1);
    cyc(20);
    check("par_err_no_ready", 32'(uart_dataready), 0);
    check("par_err_hold_kept", 32'(bus_data_o), 32'(m_hold));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
